// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared types and default constants for the PLL reset sequencer
//
// Purpose: FSM state enum, default parameter set, counter widths and the
//          release-order helper shared by the sequencer and its users.
// Ports:   none (package).
package pll_rst_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_HOLD   = 1024;
  localparam int DEF_STAGE_GAP   = 16;
  localparam int CNT_W           = 16;
  localparam int LOSS_CNT_W      = 8;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    REL_MEM   = 3'd2,
    REL_VID   = 3'd3,
    REL_CPU   = 3'd4,
    RUN       = 3'd5
  } state_e;

  // Fixed release order: mem -> vid -> cpu -> run.
  function automatic state_e next_release(input state_e s);
    case (s)
      REL_MEM: return REL_VID;
      REL_VID: return REL_CPU;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for a single asynchronous bit
//
// Purpose: bring an asynchronous level into the clk domain through STAGES flops.
// Ports:   clk_i  - destination clock
//          rst_i  - asynchronous active-high reset, clears the chain
//          d_i    - asynchronous input bit
//          q_o    - synchronised output (last stage)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - staged reset release after PLL lock
//
// Purpose: waits for a stable PLL lock, then releases the memory, video and
//          CPU resets in order, STAGE_GAP cycles apart, and raises ready.
//          Lock loss or a soft reset re-asserts all resets at once.
// Ports:   clk           - PLL output clock
//          rst           - asynchronous active-high reset
//          locked        - PLL lock, asynchronous to clk
//          sw_reset      - single-cycle soft-reset request
//          rst_mem       - memory subsystem reset (active high)
//          rst_vid       - video subsystem reset (active high)
//          rst_cpu       - CPU reset (active high)
//          ready         - high only in RUN
//          lock_loss_cnt - saturating lock-loss event count
//                          (only with PLL_RSTSEQ_LOSS_CNT_EN defined)
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_HOLD   = DEF_LOCK_HOLD,
  parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  sw_reset,
  output logic                  rst_mem,
  output logic                  rst_vid,
  output logic                  rst_cpu,
  output logic                  ready
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic             locked_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_mem_q, rst_mem_d;
  logic             rst_vid_q, rst_vid_d;
  logic             rst_cpu_q, rst_cpu_d;
  logic             ready_q, ready_d;
  logic             loss_evt;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_locked (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (locked),
    .q_o  (locked_s)
  );

  // Counter defaults to zero so every state change clears it; it only
  // increments while below the exit compare value, so it cannot wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    loss_evt = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = HOLD;
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (sw_reset) begin
          state_d = HOLD;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = REL_MEM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_MEM, REL_VID, REL_CPU: begin
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          loss_evt = 1'b1;
        end else if (sw_reset) begin
          state_d = HOLD;
        end else if (cnt_q == GAP_LAST) begin
          state_d = next_release(state_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          loss_evt = 1'b1;
        end else if (sw_reset) begin
          state_d = HOLD;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_comb begin
    rst_mem_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
    rst_vid_d = !((state_d == REL_VID) || (state_d == REL_CPU) || (state_d == RUN));
    rst_cpu_d = !((state_d == REL_CPU) || (state_d == RUN));
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      rst_mem_q <= 1'b1;
      rst_vid_q <= 1'b1;
      rst_cpu_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_mem_q <= rst_mem_d;
      rst_vid_q <= rst_vid_d;
      rst_cpu_q <= rst_cpu_d;
      ready_q   <= ready_d;
    end
  end

  assign rst_mem = rst_mem_q;
  assign rst_vid = rst_vid_q;
  assign rst_cpu = rst_cpu_q;
  assign ready   = ready_q;

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  logic unused_loss_evt;
  assign unused_loss_evt = loss_evt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  // Edge numbers counted from the first clk edge after rst is released with
  // locked already high: 2 sync edges + 1 WAIT_LOCK edge + 1024 hold cycles.
  localparam int T_MEM = 1027;
  localparam int T_VID = 1043;
  localparam int T_CPU = 1059;
  localparam int T_RDY = 1075;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic sw_reset = 1'b0;
  logic rst_mem, rst_vid, rst_cpu, ready;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
  logic       locked_b = 1'b0;
  logic       rst_mem_b, rst_vid_b, rst_cpu_b, ready_b;
  logic [7:0] loss_cnt_b;
`endif

  always #20 clk = ~clk;

  pll_reset_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .locked  (locked),
    .sw_reset(sw_reset),
    .rst_mem (rst_mem),
    .rst_vid (rst_vid),
    .rst_cpu (rst_cpu),
    .ready   (ready)
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    ,
    .lock_loss_cnt(loss_cnt)
`endif
  );

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  pll_reset_sequencer #(
    .SYNC_STAGES(2),
    .LOCK_HOLD  (2),
    .STAGE_GAP  (1)
  ) u_small (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked_b),
    .sw_reset     (1'b0),
    .rst_mem      (rst_mem_b),
    .rst_vid      (rst_vid_b),
    .rst_cpu      (rst_cpu_b),
    .ready        (ready_b),
    .lock_loss_cnt(loss_cnt_b)
  );
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic lk);
    rst      = 1'b1;
    sw_reset = 1'b0;
    locked   = lk;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; locked = 1'b0; sw_reset = 1'b0;
    tick(2);
    n_cmp++;
    if ({rst_mem, rst_vid, rst_cpu, ready} !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 1110", {rst_mem, rst_vid, rst_cpu, ready});
    end
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    n_cmp++;
    if (loss_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_loss_cnt: got %0d want 0", loss_cnt);
    end
`endif
  endtask

  task automatic test_power_up;
    logic [3:0] exp;
    restart(1'b1);
    for (int k = 1; k <= T_RDY; k++) begin
      tick(1);
      if (k == T_MEM-1 || k == T_MEM || k == T_VID-1 || k == T_VID ||
          k == T_CPU-1 || k == T_CPU || k == T_RDY-1 || k == T_RDY) begin
        exp = {k < T_MEM, k < T_VID, k < T_CPU, k >= T_RDY};
        n_cmp++;
        if ({rst_mem, rst_vid, rst_cpu, ready} !== exp) begin
          n_err++;
          $display("FAIL power_up edge %0d: got %b want %b", k,
                   {rst_mem, rst_vid, rst_cpu, ready}, exp);
        end
      end
    end
  endtask

  task automatic test_hold_glitch;
    // Drop at count 500: WAIT_LOCK at edge 506, HOLD again at 507, release at 1531.
    restart(1'b1);
    for (int k = 1; k <= 1531; k++) begin
      tick(1);
      if (k == 503) locked = 1'b0;
      if (k == 504) locked = 1'b1;
      if (k == T_MEM || k == 1530 || k == 1531) begin
        n_cmp++;
        if (rst_mem !== (k < 1531)) begin
          n_err++;
          $display("FAIL hold_glitch edge %0d: rst_mem=%b want %b", k, rst_mem, k < 1531);
        end
      end
    end
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    n_cmp++;
    if (loss_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL hold_glitch_loss_cnt: got %0d want 0", loss_cnt);
    end
`endif
  endtask

  task automatic test_run_loss;
    restart(1'b1);
    tick(T_RDY);
    locked = 1'b0;
    tick(2);
    n_cmp++;
    if ({rst_mem, rst_vid, rst_cpu, ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL run_loss_early: got %b want 0001", {rst_mem, rst_vid, rst_cpu, ready});
    end
    tick(1);
    n_cmp++;
    if ({rst_mem, rst_vid, rst_cpu, ready} !== 4'b1110) begin
      n_err++;
      $display("FAIL run_loss_assert: got %b want 1110", {rst_mem, rst_vid, rst_cpu, ready});
    end
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    n_cmp++;
    if (loss_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL run_loss_cnt: got %0d want 1", loss_cnt);
    end
`endif
    locked = 1'b1;
    for (int k = 1; k <= T_RDY; k++) begin
      tick(1);
      if (k == T_MEM-1 || k == T_MEM || k == T_RDY-1 || k == T_RDY) begin
        n_cmp++;
        if ({rst_mem, ready} !== {k < T_MEM, k >= T_RDY}) begin
          n_err++;
          $display("FAIL relock edge %0d: mem/ready got %b want %b", k,
                   {rst_mem, ready}, {k < T_MEM, k >= T_RDY});
        end
      end
    end
  endtask

  task automatic test_sw_reset;
    restart(1'b1);
    tick(T_RDY);
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    n_cmp++;
    if ({rst_mem, rst_vid, rst_cpu, ready} !== 4'b1110) begin
      n_err++;
      $display("FAIL sw_run_assert: got %b want 1110", {rst_mem, rst_vid, rst_cpu, ready});
    end
    // HOLD entered on edge 1: release at 1025, RUN at 1073.
    for (int k = 2; k <= 1073; k++) begin
      tick(1);
      if (k == 1024 || k == 1025 || k == 1072 || k == 1073) begin
        n_cmp++;
        if ({rst_mem, ready} !== {k < 1025, k >= 1073}) begin
          n_err++;
          $display("FAIL sw_run_seq edge %0d: mem/ready got %b want %b", k,
                   {rst_mem, ready}, {k < 1025, k >= 1073});
        end
      end
    end
    // Soft reset while waiting for lock is ignored.
    restart(1'b0);
    tick(3);
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    n_cmp++;
    if ({rst_mem, rst_vid, rst_cpu, ready} !== 4'b1110) begin
      n_err++;
      $display("FAIL sw_wait_lock: got %b want 1110", {rst_mem, rst_vid, rst_cpu, ready});
    end
    // Soft reset in HOLD at count 100 restarts the hold: release at 1128.
    locked = 1'b1;
    for (int k = 1; k <= 1128; k++) begin
      tick(1);
      if (k == 103) sw_reset = 1'b1;
      if (k == 104) sw_reset = 1'b0;
      if (k == T_MEM || k == 1127 || k == 1128) begin
        n_cmp++;
        if (rst_mem !== (k < 1128)) begin
          n_err++;
          $display("FAIL sw_hold edge %0d: rst_mem=%b want %b", k, rst_mem, k < 1128);
        end
      end
    end
  endtask

  task automatic test_loss_and_sw;
    // locked_s low only at edge 3, together with sw_reset: WAIT_LOCK at 3,
    // HOLD at 4, release at 1028 (sw priority would release at 1027).
    restart(1'b1);
    tick(T_RDY);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    n_cmp++;
    if ({rst_mem, rst_vid, rst_cpu, ready} !== 4'b1110) begin
      n_err++;
      $display("FAIL loss_sw_assert: got %b want 1110", {rst_mem, rst_vid, rst_cpu, ready});
    end
    for (int k = 4; k <= 1028; k++) begin
      tick(1);
      if (k == 1027 || k == 1028) begin
        n_cmp++;
        if (rst_mem !== (k < 1028)) begin
          n_err++;
          $display("FAIL loss_sw_seq edge %0d: rst_mem=%b want %b", k, rst_mem, k < 1028);
        end
      end
    end
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    n_cmp++;
    if (loss_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL loss_sw_cnt: got %0d want 1", loss_cnt);
    end
`endif
  endtask

  task automatic test_rst_mid;
    // Continues from test_loss_and_sw: REL_MEM at 1028, REL_VID from 1044 to 1059.
    tick(20);
    n_cmp++;
    if ({rst_mem, rst_vid, rst_cpu, ready} !== 4'b0010) begin
      n_err++;
      $display("FAIL rst_mid_pre: got %b want 0010", {rst_mem, rst_vid, rst_cpu, ready});
    end
    #5 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rst_mem, rst_vid, rst_cpu, ready} !== 4'b1110) begin
      n_err++;
      $display("FAIL rst_mid_async: got %b want 1110", {rst_mem, rst_vid, rst_cpu, ready});
    end
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    n_cmp++;
    if (loss_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL rst_mid_loss_cnt: got %0d want 0", loss_cnt);
    end
`endif
    restart(1'b1);
    for (int k = 1; k <= T_MEM; k++) begin
      tick(1);
      if (k == 1 || k == T_MEM-1 || k == T_MEM) begin
        n_cmp++;
        if ({rst_mem, rst_vid, rst_cpu} !== {k < T_MEM, 2'b11}) begin
          n_err++;
          $display("FAIL rst_mid_restart edge %0d: got %b want %b", k,
                   {rst_mem, rst_vid, rst_cpu}, {k < T_MEM, 2'b11});
        end
      end
    end
  endtask

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  task automatic test_saturation;
    int t;
    for (int i = 0; i < 300; i++) begin
      locked_b = 1'b1;
      t = 0;
      while (ready_b !== 1'b1 && t < 50) begin tick(1); t++; end
      n_cmp++;
      if (ready_b !== 1'b1) begin
        n_err++;
        $display("FAIL sat_ready iter %0d: ready=%b want 1", i, ready_b);
      end
      locked_b = 1'b0;
      t = 0;
      while (rst_cpu_b !== 1'b1 && t < 50) begin tick(1); t++; end
      n_cmp++;
      if (rst_cpu_b !== 1'b1) begin
        n_err++;
        $display("FAIL sat_drop iter %0d: rst_cpu=%b want 1", i, rst_cpu_b);
      end
      if (i == 254 || i == 299) begin
        n_cmp++;
        if (loss_cnt_b !== 8'd255) begin
          n_err++;
          $display("FAIL sat_cnt iter %0d: got %0d want 255", i, loss_cnt_b);
        end
      end
    end
  endtask
`endif

  initial begin
    #(40 * 40000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_hold_glitch();
    test_run_loss();
    test_sw_reset();
    test_loss_and_sw();
    test_rst_mid();
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
